// File: rtl/core_pkg.sv
// Shared core types: the data-memory request/response bundles used by the memory
// stage and by dmem_responder.
package core_pkg;

    localparam int Xlen = 32;

    typedef struct packed {
        logic [Xlen-1:0]   addr;
        logic              we;
        logic [Xlen-1:0]   wdata;
        logic [Xlen/8-1:0] wmask;
    } dmem_req_t;

    typedef struct packed {
        logic [Xlen-1:0] rdata;
        logic            err;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_responder_sram.sv
// Data word array: synchronous per-byte write, combinational read.
// Kept separate so a vendor RAM macro can replace it.
module dmem_sram #(
    parameter int Xlen       = 32,
    parameter int DepthWords = 1024
) (
    input  logic                          clk_i,
    input  logic                          we_i,
    input  logic [$clog2(DepthWords)-1:0] idx_i,
    input  logic [Xlen/8-1:0]             wmask_i,
    input  logic [Xlen-1:0]               wdata_i,
    output logic [Xlen-1:0]               rdata_o
);

    logic [Xlen-1:0] mem_q [DepthWords];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < Xlen / 8; b++) begin
                if (wmask_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, fixed response latency.
// Request/response bundles use core_pkg types, so Xlen must match core_pkg::Xlen.
module dmem_responder
    import core_pkg::*;
#(
    parameter int Xlen       = core_pkg::Xlen,
    parameter int DepthWords = 1024,
    parameter int Latency    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [Xlen-1:0]   req_addr_i,
    input  logic              req_we_i,
    input  logic [Xlen-1:0]   req_wdata_i,
    input  logic [Xlen/8-1:0] req_wmask_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [Xlen-1:0]   resp_rdata_o,
    output logic              resp_err_o
);

    localparam int OffW = $clog2(Xlen / 8);
    localparam int IdxW = $clog2(DepthWords);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    dmem_req_t       req;
    dmem_resp_t      resp_d, resp_q;
    logic [1:0]      state_d, state_q;
    logic [1:0]      cnt_d, cnt_q;
    logic            accept;
    logic            addr_err;
    logic            ram_we;
    logic [IdxW-1:0] idx;
    logic [Xlen-1:0] ram_rdata;

    assign req = '{addr: req_addr_i, we: req_we_i, wdata: req_wdata_i, wmask: req_wmask_i};

    // Faults are misaligned word addresses and any address bit above the array.
    assign idx      = req.addr[IdxW+OffW-1:OffW];
    assign addr_err = (|req.addr[OffW-1:0]) || (|req.addr[Xlen-1:IdxW+OffW]);
    assign accept   = req_valid_i && (state_q == IDLE);
    assign ram_we   = accept && req.we && !addr_err;

    dmem_sram #(
        .Xlen       (Xlen),
        .DepthWords (DepthWords)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .idx_i   (idx),
        .wmask_i (req.wmask),
        .wdata_i (req.wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resp_d.err   = addr_err;
                    resp_d.rdata = (addr_err || req.we) ? '0 : ram_rdata;
                    if (Latency > 1) begin
                        state_d = WAIT;
                        cnt_d   = 2'(Latency - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = resp_q.rdata;
    assign resp_err_o   = resp_q.err;

endmodule
